pudding_loader: RTL and testbench

PUDDING_LOADER -- requirements
Module: pudding_loader

---
 rtl/pudding_pkg.sv | 22 ++
 rtl/pudding_loader.sv | 148 ++++++++++++++
 tb/tb_pudding_loader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pudding_pkg.sv
// -----------------------------------------------------------------------------
// pudding_pkg
// Shared definitions for the pudding daisychain loader.
//   DEFAULT_CHAIN_BITS : default daisychain length in bits (multiple of 8)
//   BYTES_PER_FRAME    : bytes needed to fill a default-length chain
//   loader_state_e     : loader FSM state encoding
// -----------------------------------------------------------------------------
package pudding_pkg;

  localparam int DEFAULT_CHAIN_BITS = 128;
  localparam int BYTES_PER_FRAME    = DEFAULT_CHAIN_BITS / 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_SHIFT_HI  = 3'd2,
    ST_SHIFT_LO  = 3'd3,
    ST_XFER_HI   = 3'd4,
    ST_XFER_LO   = 3'd5
  } loader_state_e;

endpackage

// File: rtl/pudding_loader.sv
// -----------------------------------------------------------------------------
// pudding_loader
// Byte-stream front end for the pudding daisychain. Each accepted byte is
// serialized MSB first onto the chain (byte 0 of a frame ends up in the top
// chain bits). After a full frame the chain is committed into the design
// state (transfer with dir=1) and done_o pulses. In IDLE, restore_req copies
// the design state back into the chain instead (transfer with dir=0).
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   byte_data    : payload byte
//   byte_valid   : byte_data is valid
//   byte_ready   : loader accepts a byte this cycle
//   restore_req  : request a state->chain transfer (honoured only in IDLE)
//   datum_o      : serial chain data       (ui_in[0])
//   shift_o      : chain shift strobe      (ui_in[1])
//   transfer_o   : chain transfer strobe   (ui_in[2])
//   dir_o        : transfer direction      (ui_in[3]); 1 = chain->state
//   stateen_o    : state enable            (ui_in[4]); 1 whenever out of reset
//   busy_o       : FSM not in IDLE
//   done_o       : one-cycle pulse when a frame is committed
// -----------------------------------------------------------------------------
module pudding_loader
  import pudding_pkg::*;
#(
  parameter int CHAIN_BITS = DEFAULT_CHAIN_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       restore_req,
  output logic       datum_o,
  output logic       shift_o,
  output logic       transfer_o,
  output logic       dir_o,
  output logic       stateen_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int              NUM_BYTES = CHAIN_BITS / 8;
  localparam int              BCW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(NUM_BYTES - 1);

  loader_state_e  state;
  logic [BCW-1:0] byte_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift_byte;
  logic           running;   // 0 only until the first edge after reset release
  logic           accept;

  // NOTE: byte_ready is the one deliberate combinational output: restore_req
  // must be able to take priority over a byte in the very same IDLE cycle.
  assign byte_ready = running &&
                      (((state == ST_IDLE) && !restore_req) || (state == ST_WAIT_BYTE));
  assign accept     = byte_valid && byte_ready;
  assign stateen_o  = running;

  // NOTE: all state and every registered output update with non-blocking
  // assignments so the whole block sees pre-edge values consistently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      shift_byte <= '0;
      running    <= 1'b0;
      datum_o    <= 1'b0;
      shift_o    <= 1'b0;
      transfer_o <= 1'b0;
      dir_o      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      running <= 1'b1;
      done_o  <= 1'b0;

      case (state)
        ST_IDLE, ST_WAIT_BYTE: begin
          if ((state == ST_IDLE) && running && restore_req) begin
            state      <= ST_XFER_HI;
            transfer_o <= 1'b1;
            dir_o      <= 1'b0;
            busy_o     <= 1'b1;
          end else if (accept) begin
            // Present bit 7 immediately so shift_o rises the cycle after acceptance.
            state      <= ST_SHIFT_HI;
            shift_byte <= byte_data;
            bit_cnt    <= 3'd7;
            datum_o    <= byte_data[7];
            shift_o    <= 1'b1;
            busy_o     <= 1'b1;
          end
        end

        ST_SHIFT_HI: begin
          state   <= ST_SHIFT_LO;
          shift_o <= 1'b0;           // datum_o held through the low half
        end

        ST_SHIFT_LO: begin
          if (bit_cnt != 3'd0) begin
            state      <= ST_SHIFT_HI;
            bit_cnt    <= bit_cnt - 3'd1;
            shift_byte <= {shift_byte[6:0], 1'b0};
            datum_o    <= shift_byte[6];
            shift_o    <= 1'b1;
          end else begin
            datum_o <= 1'b0;
            if (byte_cnt != LAST_BYTE) begin
              state    <= ST_WAIT_BYTE;
              byte_cnt <= byte_cnt + 1'b1;
            end else begin
              state      <= ST_XFER_HI;
              transfer_o <= 1'b1;
              dir_o      <= 1'b1;
            end
          end
        end

        ST_XFER_HI: begin
          state      <= ST_XFER_LO;
          transfer_o <= 1'b0;
          dir_o      <= 1'b0;
          done_o     <= dir_o;       // only a frame commit reports done
        end

        ST_XFER_LO: begin
          state    <= ST_IDLE;
          busy_o   <= 1'b0;
          byte_cnt <= '0;
        end

        default: begin
          state      <= ST_IDLE;
          datum_o    <= 1'b0;
          shift_o    <= 1'b0;
          transfer_o <= 1'b0;
          dir_o      <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pudding_loader.sv
// -----------------------------------------------------------------------------
// tb_pudding_loader
// Scoreboard bench for pudding_loader. Stimulus pushes the expected chain
// events (shift bits, transfers, done pulses) into a queue; a monitor on the
// falling edge pops and compares them, and keeps a behavioural model of the
// downstream chain/state so frame contents can be checked.
// -----------------------------------------------------------------------------
module tb_pudding_loader;
  import pudding_pkg::*;

  localparam int CB = 128;

  typedef enum logic [1:0] {EV_SHIFT, EV_XFER, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e        kind;
    logic            bitv;
    logic [CB-1:0]   data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_valid = 1'b0;
  logic       restore_req = 1'b0;
  logic       byte_ready, datum_o, shift_o, transfer_o, dir_o, stateen_o, busy_o, done_o;

  pudding_loader #(.CHAIN_BITS(CB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .restore_req (restore_req),
    .datum_o     (datum_o),
    .shift_o     (shift_o),
    .transfer_o  (transfer_o),
    .dir_o       (dir_o),
    .stateen_o   (stateen_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  ev_t           exp_q[$];
  logic [CB-1:0] frame_exp = '0;
  logic [CB-1:0] last_frame = '0;
  int            frame_idx = 0;
  int            shift_seen = 0;

  // Downstream model: chain shift register and design state.
  logic [CB-1:0] mchain = '0;
  logic [CB-1:0] mstate = '0;
  logic          prev_shift = 1'b0;
  logic          prev_xfer = 1'b0;

  task automatic check(input string name, input logic [CB-1:0] act, input logic [CB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input logic b, input logic [CB-1:0] d);
    ev_t e;
    e.kind = k;
    e.bitv = b;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      prev_shift = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (shift_o || transfer_o)
        check("shift_xfer_exclusive", {127'd0, shift_o && transfer_o}, '0);

      if (shift_o && !prev_shift) begin
        mchain = {mchain[CB-2:0], datum_o};
        shift_seen++;
        if (exp_q.size() == 0) check("unexpected_shift", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("ev_kind_shift", CB'(EV_SHIFT), CB'(e.kind));
          check("shift_datum", {127'd0, datum_o}, {127'd0, e.bitv});
        end
      end

      if (transfer_o && !prev_xfer) begin
        if (dir_o) mstate = mchain;
        else       mchain = mstate;
        if (exp_q.size() == 0) check("unexpected_xfer", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("ev_kind_xfer", CB'(EV_XFER), CB'(e.kind));
          check("xfer_dir", {127'd0, dir_o}, {127'd0, e.bitv});
          check("xfer_chain", mchain, e.data);
        end
      end

      if (done_o) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("ev_kind_done", CB'(EV_DONE), CB'(e.kind));
          check("done_state", mstate, e.data);
        end
      end

      prev_shift = shift_o;
      prev_xfer  = transfer_o;
    end
  end

  // Offer a byte, wait (bounded) for acceptance, and queue its expected events.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    byte_data  = b;
    byte_valid = 1'b1;
    #1;
    while (!byte_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!byte_ready) begin
      check("accept_timeout", 0, 1);
      byte_valid = 1'b0;
    end else begin
      for (int i = 7; i >= 0; i--) push_ev(EV_SHIFT, b[i], '0);
      frame_exp = {frame_exp[CB-9:0], b};
      frame_idx++;
      if (frame_idx == CB / 8) begin
        push_ev(EV_XFER, 1'b1, frame_exp);
        push_ev(EV_DONE, 1'b1, frame_exp);
        last_frame = frame_exp;
        frame_idx  = 0;
      end
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    @(negedge clk);
    while (busy_o && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("idle_timeout", {127'd0, busy_o}, '0);
  endtask

  initial begin
    logic [7:0] a5;
    int waited;
    a5 = 8'hA5;

    // Reset: every output low, including stateen_o and byte_ready.
    repeat (3) @(negedge clk);
    #1;
    check("rst_byte_ready", {127'd0, byte_ready}, '0);
    check("rst_stateen",    {127'd0, stateen_o},  '0);
    check("rst_busy",       {127'd0, busy_o},     '0);
    check("rst_done",       {127'd0, done_o},     '0);
    check("rst_shift",      {127'd0, shift_o},    '0);
    check("rst_transfer",   {127'd0, transfer_o}, '0);
    check("rst_dir",        {127'd0, dir_o},      '0);
    check("rst_datum",      {127'd0, datum_o},    '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_stateen", {127'd0, stateen_o},  {127'd0, 1'b1});
    check("post_rst_ready",   {127'd0, byte_ready}, {127'd0, 1'b1});
    check("post_rst_busy",    {127'd0, busy_o},     '0);

    // Full frame 0x01..0x10.
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    wait_idle();
    check("frame1_shift_count", CB'(shift_seen), CB'(128));
    check("frame1_uo_out", CB'(mstate[127:120]), CB'(8'h01));
    check("frame1_tail",   CB'(mstate[7:0]),     CB'(8'h10));

    // Restore wins over a simultaneous byte.
    @(negedge clk);
    restore_req = 1'b1;
    byte_valid  = 1'b1;
    byte_data   = 8'h77;
    #1;
    check("restore_byte_ready", {127'd0, byte_ready}, '0);
    push_ev(EV_XFER, 1'b0, last_frame);
    @(posedge clk);
    #1;
    restore_req = 1'b0;
    byte_valid  = 1'b0;
    check("restore_transfer", {127'd0, transfer_o}, {127'd0, 1'b1});
    check("restore_dir",      {127'd0, dir_o},      '0);
    check("restore_busy",     {127'd0, busy_o},     {127'd0, 1'b1});
    @(posedge clk);
    #1;
    check("restore_xfer_lo", {127'd0, transfer_o}, '0);
    check("restore_no_done", {127'd0, done_o},     '0);
    @(posedge clk);
    #1;
    check("restore_idle", {127'd0, busy_o}, '0);
    check("restore_uo_out", CB'(mchain[127:120]), CB'(8'h01));

    // Byte 0xA5 timing: shift high on alternate cycles, MSB first.
    send_byte(a5);
    for (int i = 0; i < 16; i++) begin
      check("a5_shift", {127'd0, shift_o}, {127'd0, (i % 2 == 0)});
      if (i % 2 == 0) check("a5_datum", {127'd0, datum_o}, {127'd0, a5[7 - i / 2]});
      check("a5_ready", {127'd0, byte_ready}, '0);
      @(posedge clk);
      #1;
    end
    check("a5_wait_ready", {127'd0, byte_ready}, {127'd0, 1'b1});

    // WAIT_BYTE stall with restore_req asserted: nothing moves.
    restore_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("stall_shift",    {127'd0, shift_o},    '0);
      check("stall_transfer", {127'd0, transfer_o}, '0);
      check("stall_busy",     {127'd0, busy_o},     {127'd0, 1'b1});
      check("stall_ready",    {127'd0, byte_ready}, {127'd0, 1'b1});
    end
    restore_req = 1'b0;
    for (int i = 1; i < 16; i++) send_byte(8'(i * 17));
    wait_idle();
    check("frame2_uo_out", CB'(mstate[127:120]), CB'(8'hA5));

    // Reset mid-frame after 5 bytes; the next 16 bytes form a fresh frame.
    for (int i = 0; i < 5; i++) send_byte(8'h3C);
    waited = 0;
    @(negedge clk);
    while (!byte_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_reset", {127'd0, byte_ready}, {127'd0, 1'b1});
    #1;
    rst_n     = 1'b0;
    frame_idx = 0;
    frame_exp = '0;
    repeat (2) @(negedge clk);
    check("midrst_busy",    {127'd0, busy_o},     '0);
    check("midrst_ready",   {127'd0, byte_ready}, '0);
    check("midrst_stateen", {127'd0, stateen_o},  '0);
    check("midrst_queue",   CB'(exp_q.size()),    '0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'hFF);
    wait_idle();
    check("midrst_all_ones", mstate, {CB{1'b1}});

    // Everything queued must have been observed.
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("queue_drained", CB'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
